// File: rtl/exec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// exec_ctrl_pkg : shared state encoding for the execution sequencer
// Rev 1.0
// ============================================================================
package exec_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } exec_state_t;

endpackage
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// switch_debouncer : 2-FF synchroniser, level debouncer and registered press pulse
// Rev 1.0
// ============================================================================
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_signal,
  input  logic reset,
  input  logic i_switch,
  output logic o_press
);

  localparam int              CW     = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   c_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  always_ff @(posedge clk_signal or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= i_switch;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_level) begin
        if (r_cnt == c_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/exec_step_controller.sv
`default_nettype none
// ============================================================================
// exec_step_controller : gates the core clock enable for free-run / single-step / halt
// Rev 1.0
// ============================================================================
module exec_step_controller
  import exec_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_CYCLES     = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk_signal,
  input  logic             reset,
  input  logic             switch,
  input  logic             run_mode,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             step_done,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int            SW           = (STEP_CYCLES < 1) ? 1 : $clog2(STEP_CYCLES + 1);
  localparam logic [SW-1:0] c_STEP_LOAD  = SW'(STEP_CYCLES);
  localparam logic [SW-1:0] c_STEP_FINAL = SW'(1);

  generate
    if (STEP_CYCLES < 1) begin : g_bad_step_cycles
      $error("exec_step_controller: STEP_CYCLES must be at least 1");
    end
  endgenerate

  logic             w_press;
  exec_state_t      r_state;
  logic             r_cpu_en;
  logic             r_step_done;
  logic             r_halted;
  logic [SW-1:0]    r_step_cnt;
  logic [CNT_W-1:0] r_cycle_count;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_signal(clk_signal),
    .reset     (reset),
    .i_switch  (switch),
    .o_press   (w_press)
  );

  // cpu_en is registered alongside the next state so it is high exactly while in STEP/RUN.
  always_ff @(posedge clk_signal or posedge reset) begin
    if (reset) begin
      r_state       <= ST_WAIT;
      r_cpu_en      <= 1'b0;
      r_step_done   <= 1'b0;
      r_halted      <= 1'b0;
      r_step_cnt    <= '0;
      r_cycle_count <= '0;
    end else begin
      r_step_done <= 1'b0;
      if (r_cpu_en) begin
        r_cycle_count <= r_cycle_count + 1'b1;
      end
      case (r_state)
        ST_WAIT: begin
          if (halt_req) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
            r_cpu_en <= 1'b0;
          end else if (run_mode) begin
            r_state  <= ST_RUN;
            r_cpu_en <= 1'b1;
          end else if (w_press) begin
            r_state    <= ST_STEP;
            r_step_cnt <= c_STEP_LOAD;
            r_cpu_en   <= 1'b1;
          end else begin
            r_cpu_en <= 1'b0;
          end
        end
        ST_STEP: begin
          if (halt_req) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
            r_cpu_en <= 1'b0;
          end else if (r_step_cnt == c_STEP_FINAL) begin
            r_state     <= ST_WAIT;
            r_step_done <= 1'b1;
            r_cpu_en    <= 1'b0;
          end else begin
            r_step_cnt <= r_step_cnt - 1'b1;
            r_cpu_en   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (halt_req) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
            r_cpu_en <= 1'b0;
          end else if (!run_mode) begin
            r_state  <= ST_WAIT;
            r_cpu_en <= 1'b0;
          end else begin
            r_cpu_en <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_HALT;
          r_halted <= 1'b1;
          r_cpu_en <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_en      = r_cpu_en;
  assign step_done   = r_step_done;
  assign halted      = r_halted;
  assign state       = r_state;
  assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_exec_step_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_exec_step_controller : three instances (STEP_CYCLES 1/5/16) against a behavioural model
// Rev 1.0
// ============================================================================
module tb_exec_step_controller;

  localparam int N   = 3;
  localparam int DEB = 4;

  logic        clk_signal = 1'b0;
  logic        reset;
  logic        switch;
  logic        run_mode;
  logic        halt_req;
  logic        en   [N];
  logic        done [N];
  logic        hlt  [N];
  logic [1:0]  st   [N];
  logic [31:0] cc   [N];

  always #5 clk_signal = ~clk_signal;

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      exec_step_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .STEP_CYCLES    ((g == 0) ? 1 : (g == 1) ? 5 : 16),
        .CNT_W          (32)
      ) u_dut (
        .clk_signal (clk_signal),
        .reset      (reset),
        .switch     (switch),
        .run_mode   (run_mode),
        .halt_req   (halt_req),
        .cpu_en     (en[g]),
        .step_done  (done[g]),
        .halted     (hlt[g]),
        .state      (st[g]),
        .cycle_count(cc[g])
      );
    end
  endgenerate

  function automatic int steps_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 5 : 16;
  endfunction

  // Behavioural model: modes 0 idle, 1 stepping, 2 running, 3 halted.
  int          m_mode [N];
  int          m_rem  [N];
  bit          m_done [N];
  logic [31:0] m_cnt  [N];
  bit          dq[$] = '{1'b0, 1'b0};
  bit          m_level, m_d, m_rise, m_press, m_p1, m_p2;
  int          m_run;

  always @(posedge clk_signal or posedge reset) begin
    if (reset) begin
      dq = '{1'b0, 1'b0};
      m_level = 0; m_run = 0; m_p1 = 0; m_p2 = 0;
      for (int i = 0; i < N; i++) begin
        m_mode[i] = 0; m_rem[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      // A debounced rise reaches the sequencer two edges later.
      m_press = m_p2;
      for (int i = 0; i < N; i++) begin
        if (m_mode[i] == 1 || m_mode[i] == 2) m_cnt[i] = m_cnt[i] + 1;
        m_done[i] = 0;
        if (m_mode[i] != 3 && halt_req) m_mode[i] = 3;
        else if (m_mode[i] == 0) begin
          if (run_mode) m_mode[i] = 2;
          else if (m_press) begin m_mode[i] = 1; m_rem[i] = steps_of(i); end
        end else if (m_mode[i] == 1) begin
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) begin m_mode[i] = 0; m_done[i] = 1; end
        end else if (m_mode[i] == 2) begin
          if (!run_mode) m_mode[i] = 0;
        end
      end
      dq.push_back(switch);
      m_d = dq.pop_front();
      m_rise = 0;
      if (m_d != m_level) begin
        m_run++;
        if (m_run == DEB) begin m_level = m_d; m_run = 0; m_rise = m_d; end
      end else begin
        m_run = 0;
      end
      m_p2 = m_p1;
      m_p1 = m_rise;
    end
  end

  int checks = 0;
  int errors = 0;
  int tcount;
  int en_seen   [N];
  int done_seen [N];
  int first_en  [N];
  int last_en   [N];

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, idx, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    tcount = 0;
    for (int i = 0; i < N; i++) begin
      en_seen[i] = 0; done_seen[i] = 0; first_en[i] = -1; last_en[i] = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk_signal);
    #1;
    tcount++;
    for (int i = 0; i < N; i++) begin
      chk("cpu_en",      i, longint'(en[i]),   longint'(m_mode[i] == 1 || m_mode[i] == 2));
      chk("step_done",   i, longint'(done[i]), longint'(m_done[i]));
      chk("halted",      i, longint'(hlt[i]),  longint'(m_mode[i] == 3));
      chk("state",       i, longint'(st[i]),   longint'(m_mode[i]));
      chk("cycle_count", i, longint'(cc[i]),   longint'(m_cnt[i]));
      if (en[i] === 1'b1) begin
        en_seen[i]++;
        if (first_en[i] < 0) first_en[i] = tcount;
        last_en[i] = tcount;
      end
      if (done[i] === 1'b1) done_seen[i]++;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    reset = 1'b1; switch = 1'b0; run_mode = 1'b0; halt_req = 1'b0;
    clear_stats();
    #50;
    reset = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_cpu_en", i, longint'(en[i]), 0);
      chk("rst_state",  i, longint'(st[i]), 0);
      chk("rst_count",  i, longint'(cc[i]), 0);
      chk("rst_halted", i, longint'(hlt[i]), 0);
    end

    // Idle after reset
    clear_stats();
    run(40);
    for (int i = 0; i < N; i++) begin
      chk("idle_en_cycles", i, en_seen[i], 0);
      chk("idle_count",     i, longint'(cc[i]), 0);
    end

    // Single press, latency and one-cycle burst
    clear_stats();
    switch = 1'b1; run(10);
    switch = 1'b0; run(20);
    chk("press_latency",  0, first_en[0] - 1, 7);
    chk("step1_en_cycles", 0, en_seen[0], 1);
    chk("step1_done",      0, done_seen[0], 1);
    chk("step1_count",     0, longint'(cc[0]), 1);
    switch = 1'b1; run(10);
    switch = 1'b0; run(20);
    chk("step1_count2",    0, longint'(cc[0]), 2);

    // Glitchy switch never debounces
    do_reset();
    clear_stats();
    switch = 1'b1; run(3);
    switch = 1'b0; run(1);
    switch = 1'b1; run(3);
    switch = 1'b0; run(20);
    for (int i = 0; i < N; i++) begin
      chk("glitch_en_cycles", i, en_seen[i], 0);
      chk("glitch_count",     i, longint'(cc[i]), 0);
    end

    // Five-cycle burst
    do_reset();
    clear_stats();
    switch = 1'b1; run(10);
    switch = 1'b0; run(30);
    chk("step5_en_cycles", 1, en_seen[1], 5);
    chk("step5_span",      1, last_en[1] - first_en[1] + 1, 5);
    chk("step5_done",      1, done_seen[1], 1);
    chk("step5_count",     1, longint'(cc[1]), 5);

    // Second press lands inside the 16-cycle burst and is dropped
    do_reset();
    clear_stats();
    switch = 1'b1; run(6);
    switch = 1'b0; run(5);
    switch = 1'b1; run(6);
    switch = 1'b0; run(40);
    chk("drop_count16", 2, longint'(cc[2]), 16);
    chk("drop_done16",  2, done_seen[2], 1);
    chk("drop_count5",  1, longint'(cc[1]), 10);
    chk("drop_count1",  0, longint'(cc[0]), 2);

    // Free run then halt
    do_reset();
    clear_stats();
    run_mode = 1'b1; run(20);
    run_mode = 1'b0; run(3);
    for (int i = 0; i < N; i++) begin
      chk("run_count", i, longint'(cc[i]), 20);
      chk("run_state", i, longint'(st[i]), 0);
    end
    run_mode = 1'b1; run(5);
    halt_req = 1'b1; run(1);
    halt_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("halt_en",     i, longint'(en[i]), 0);
      chk("halt_halted", i, longint'(hlt[i]), 1);
    end
    switch = 1'b1; run(10);
    switch = 1'b0; run_mode = 1'b0; run(5);
    run_mode = 1'b1; run(5);
    for (int i = 0; i < N; i++) begin
      chk("halt_sticky_state", i, longint'(st[i]), 3);
      chk("halt_frozen_count", i, longint'(cc[i]), 25);
    end
    run_mode = 1'b0;

    // Async reset in the middle of a burst
    do_reset();
    clear_stats();
    switch = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (en[1] === 1'b1) found = 1;
    end
    chk("burst_start_seen", 1, longint'(found), 1);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("async_en",     i, longint'(en[i]), 0);
      chk("async_halted", i, longint'(hlt[i]), 0);
      chk("async_count",  i, longint'(cc[i]), 0);
      chk("async_done",   i, longint'(done[i]), 0);
    end
    switch = 1'b0;
    run(2);
    reset = 1'b0;
    clear_stats();
    run(20);
    for (int i = 0; i < N; i++) begin
      chk("post_reset_done", i, done_seen[i], 0);
      chk("post_reset_en",   i, en_seen[i], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
